// File: rtl/ce_result_packer_pkg.sv
// ce_result_packer_pkg: shared types and constants for the compute-engine result packer.
//   CE_RES_W        - width of one FP16 result
//   ce_pack_state_t - packer FSM state (IDLE=0, COLLECT=1, DRAIN=2, DONE=3)
package ce_result_packer_pkg;

  localparam int unsigned CE_RES_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } ce_pack_state_t;

endpackage

// File: rtl/ce_word_fifo.sv
// ce_word_fifo: synchronous FIFO with registered full/empty flags.
//   i_clk, i_reset_n      - clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_push_data   - write request and data (ignored when full)
//   i_pop, o_pop_data     - read request (ignored when empty), head-of-queue data
//   o_full, o_empty       - registered occupancy flags
module ce_word_fifo
  import ce_result_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !full_q;
  assign do_pop  = i_pop && !empty_q;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers and flags.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: the flags decide what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_full     = full_q;
  assign o_empty    = empty_q;

endmodule

// File: rtl/ce_result_packer.sv
// ce_result_packer: packs PACK FP16 results per output word, buffers words in a
// DEPTH-entry FIFO and drains them under downstream full/almost-full backpressure.
//   i_clk, i_reset_n                  - clock, synchronous active-low reset
//   i_tile_en, i_tile_expected        - tile start pulse and its result count
//   i_res_valid, i_res_data, o_res_ready - result input handshake
//   o_result_data/keep/valid          - packed output word, lane mask, one-cycle pulse
//   i_result_full, i_result_afull     - downstream backpressure
//   o_tile_done                       - one-cycle pulse after the tile's last word left
//   o_state, o_result_count, o_err    - FSM state, accepted results, sticky protocol error
//   o_stall_cycles                    - backpressure stall counter; live only when
//                                       CE_RESULT_STALL_CNT_EN is defined, else 0
module ce_result_packer
  import ce_result_packer_pkg::*;
#(
  parameter int unsigned RES_W = CE_RES_W,
  parameter int unsigned PACK  = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_tile_en,
  input  logic [CNT_W-1:0]      i_tile_expected,
  input  logic                  i_res_valid,
  input  logic [RES_W-1:0]      i_res_data,
  output logic                  o_res_ready,
  output logic [PACK*RES_W-1:0] o_result_data,
  output logic [PACK-1:0]       o_result_keep,
  output logic                  o_result_valid,
  input  logic                  i_result_full,
  input  logic                  i_result_afull,
  output logic                  o_tile_done,
  output logic [1:0]            o_state,
  output logic [CNT_W-1:0]      o_result_count,
  output logic                  o_err,
  output logic [15:0]           o_stall_cycles
);

  localparam int unsigned WORD_W  = PACK * RES_W;
  localparam int unsigned IDX_W   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned FIFO_W  = WORD_W + PACK;
  localparam int unsigned STALL_W = 16;

  ce_pack_state_t    state_q;
  ce_pack_state_t    state_d;

  logic [CNT_W-1:0]  exp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] pack_data_q;
  logic [PACK-1:0]   pack_keep_q;
  logic [WORD_W-1:0] merged_data;
  logic [PACK-1:0]   merged_keep;
  logic [WORD_W-1:0] out_data_q;
  logic [PACK-1:0]   out_keep_q;
  logic              out_valid_q;
  logic              err_q;

  logic              res_ready;
  logic              tile_done;
  logic              tile_start;
  logic              accept;
  logic              last_acc;
  logic              push;
  logic              pop;
  logic              proto_err;
  logic [FIFO_W-1:0] fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;

  assign tile_start = (state_q == S_IDLE) && i_tile_en;
  assign accept     = i_res_valid && res_ready;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign last_acc   = accept && (cnt_inc == exp_q);
  // A word leaves the pack register when its top lane fills or the tile ends.
  assign push       = accept && ((idx_q == IDX_W'(PACK - 1)) || (cnt_inc == exp_q));
  assign pop        = (state_q != S_IDLE) && !fifo_empty && !i_result_afull && !i_result_full;
  assign proto_err  = (i_tile_en && (state_q != S_IDLE)) || (i_res_valid && (state_q == S_IDLE));

  // Current pack register with the incoming result dropped into lane idx.
  always_comb begin
    merged_data = pack_data_q;
    merged_keep = pack_keep_q;
    for (int unsigned l = 0; l < PACK; l++) begin
      if (idx_q == IDX_W'(l)) begin
        merged_data[l*RES_W +: RES_W] = i_res_data;
        merged_keep[l]                = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    res_ready = 1'b0;
    tile_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_tile_en) begin
          state_d = (i_tile_expected == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        // Full flag is registered, so a pop this cycle cannot reopen ready.
        res_ready = !fifo_full && (cnt_q < exp_q);
        if (last_acc) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tile_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tile bookkeeping, pack register, output word and error flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      exp_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      pack_data_q <= '0;
      pack_keep_q <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (tile_start) begin
        exp_q       <= i_tile_expected;
        cnt_q       <= '0;
        idx_q       <= '0;
        pack_data_q <= '0;
        pack_keep_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_inc;
        if (push) begin
          idx_q       <= '0;
          pack_data_q <= '0;
          pack_keep_q <= '0;
        end else begin
          idx_q       <= idx_q + IDX_W'(1);
          pack_data_q <= merged_data;
          pack_keep_q <= merged_keep;
        end
      end
      if (proto_err) begin
        err_q <= 1'b1;
      end
      out_valid_q <= pop;
      if (pop) begin
        out_data_q <= fifo_rd[WORD_W-1:0];
        out_keep_q <= fifo_rd[FIFO_W-1 -: PACK];
      end
    end
  end

  ce_word_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (push),
    .i_push_data ({merged_keep, merged_data}),
    .i_pop       (pop),
    .o_pop_data  (fifo_rd),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

`ifdef CE_RESULT_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  // Cycles a buffered word was held back by downstream; saturating.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_q <= '0;
    end else if (tile_start) begin
      stall_q <= '0;
    end else if (!fifo_empty && (i_result_afull || i_result_full) && !(&stall_q)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

  assign o_res_ready    = res_ready;
  assign o_tile_done    = tile_done;
  assign o_state        = state_q;
  assign o_result_count = cnt_q;
  assign o_result_data  = out_data_q;
  assign o_result_keep  = out_keep_q;
  assign o_result_valid = out_valid_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_ce_result_packer.sv
// tb_ce_result_packer: randomized scoreboard bench for ce_result_packer.
// Words expected from a lane-packing reference model are queued on acceptance;
// a monitor pops and compares on every o_result_valid and checks each tile_done.
module tb_ce_result_packer;

  localparam int unsigned RES_W  = 16;
  localparam int unsigned PACK   = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = PACK * RES_W;

  logic                  clk = 1'b0;
  logic                  i_reset_n;
  logic                  i_tile_en;
  logic [CNT_W-1:0]      i_tile_expected;
  logic                  i_res_valid;
  logic [RES_W-1:0]      i_res_data;
  logic                  o_res_ready;
  logic [WORD_W-1:0]     o_result_data;
  logic [PACK-1:0]       o_result_keep;
  logic                  o_result_valid;
  logic                  i_result_full;
  logic                  i_result_afull;
  logic                  o_tile_done;
  logic [1:0]            o_state;
  logic [CNT_W-1:0]      o_result_count;
  logic                  o_err;
  logic [15:0]           o_stall_cycles;

  ce_result_packer #(
    .RES_W (RES_W),
    .PACK  (PACK),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (i_reset_n),
    .i_tile_en       (i_tile_en),
    .i_tile_expected (i_tile_expected),
    .i_res_valid     (i_res_valid),
    .i_res_data      (i_res_data),
    .o_res_ready     (o_res_ready),
    .o_result_data   (o_result_data),
    .o_result_keep   (o_result_keep),
    .o_result_valid  (o_result_valid),
    .i_result_full   (i_result_full),
    .i_result_afull  (i_result_afull),
    .o_tile_done     (o_tile_done),
    .o_state         (o_state),
    .o_result_count  (o_result_count),
    .o_err           (o_err),
    .o_stall_cycles  (o_stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // Reference model and scoreboard.
  logic [WORD_W-1:0] exp_data_q [$];
  logic [PACK-1:0]   exp_keep_q [$];
  int                valid_cycles [$];
  logic [WORD_W-1:0] m_data;
  logic [PACK-1:0]   m_keep;
  int                m_idx;
  int                m_cnt;
  int                m_exp;
  int                m_words;
  int                exp_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int n);
    m_data  = '0;
    m_keep  = '0;
    m_idx   = 0;
    m_cnt   = 0;
    m_exp   = n;
    m_words = 0;
  endtask

  // Lanes fill in arrival order; a word closes at PACK results or at the tile's last result.
  task automatic model_accept(input logic [RES_W-1:0] d);
    m_data[m_idx*RES_W +: RES_W] = d;
    m_keep[m_idx] = 1'b1;
    m_idx++;
    m_cnt++;
    if (m_idx == PACK || m_cnt == m_exp) begin
      exp_data_q.push_back(m_data);
      exp_keep_q.push_back(m_keep);
      m_words++;
      m_data = '0;
      m_keep = '0;
      m_idx  = 0;
    end
  endtask

  // Monitor: every emitted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (i_reset_n && o_result_valid) begin
      valid_cycles.push_back(cyc);
      if (exp_data_q.size() == 0) begin
        chk("unexpected_word", 64'(o_result_data), 64'(0));
      end else begin
        chk("word_data", 64'(o_result_data), 64'(exp_data_q.pop_front()));
        chk("word_keep", 64'(o_result_keep), 64'(exp_keep_q.pop_front()));
      end
    end
    if (i_reset_n && o_tile_done) begin
      chk("done_words_left", 64'(exp_data_q.size()), 64'(0));
      chk("done_count", 64'(o_result_count), 64'(m_exp));
    end
  end

  task automatic check_reset_outputs();
    chk("rst_valid", 64'(o_result_valid), 64'(0));
    chk("rst_data", 64'(o_result_data), 64'(0));
    chk("rst_keep", 64'(o_result_keep), 64'(0));
    chk("rst_ready", 64'(o_res_ready), 64'(0));
    chk("rst_done", 64'(o_tile_done), 64'(0));
    chk("rst_state", 64'(o_state), 64'(0));
    chk("rst_count", 64'(o_result_count), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    chk("rst_stall", 64'(o_stall_cycles), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset_n      = 1'b0;
    i_tile_en      = 1'b0;
    i_res_valid    = 1'b0;
    i_result_afull = 1'b0;
    i_result_full  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_data_q.delete();
    exp_keep_q.delete();
    valid_cycles.delete();
    i_reset_n = 1'b1;
  endtask

  // One tile: start pulse, then randomized valid/backpressure until o_tile_done.
  // stall_mode holds afull until FIFO fills and 20 more cycles pass.
  task automatic run_tile(input int n, input int vpct, input int apct, input int fpct,
                          input bit stall_mode, input bit poke_err,
                          output int first_cyc, output int cyc_to_done);
    int  acc   = 0;
    int  hold  = 0;
    int  guard = 0;
    bit  done  = 0;
    first_cyc = -1;
    @(negedge clk);
    i_res_valid     = 1'b0;
    i_tile_en       = 1'b1;
    i_tile_expected = CNT_W'(n);
    model_clear(n);
    exp_stall = 0;
    @(negedge clk);
    i_tile_en = 1'b0;
    while (!done && guard < 3000) begin
      if (o_tile_done) begin
        done           = 1;
        i_res_valid    = 1'b0;
        i_result_afull = 1'b0;
        i_result_full  = 1'b0;
      end else begin
        if (stall_mode) begin
          i_result_full  = 1'b0;
          i_result_afull = (hold < 20);
          if (i_result_afull && m_words > 0) exp_stall++;
        end else begin
          i_result_afull = (($urandom % 100) < apct);
          i_result_full  = (($urandom % 100) < fpct);
        end
        if (poke_err && guard == 3) begin
          i_tile_en       = 1'b1;
          i_tile_expected = CNT_W'(n + 5);
        end else begin
          i_tile_en = 1'b0;
        end
        i_res_valid = (($urandom % 100) < vpct);
        i_res_data  = RES_W'($urandom);
        if (i_res_valid && o_res_ready) begin
          if (first_cyc < 0) first_cyc = cyc;
          model_accept(i_res_data);
          acc++;
        end
        if (stall_mode && i_result_afull && acc >= 32 && !o_res_ready) begin
          hold++;
          if (hold == 20) chk("ready_drop_accepts", 64'(acc), 64'(32));
        end
        guard++;
        @(negedge clk);
      end
    end
    cyc_to_done = guard;
    if (!done) begin
      chk("tile_timeout", 64'(1), 64'(0));
      i_res_valid    = 1'b0;
      i_tile_en      = 1'b0;
      i_result_afull = 1'b0;
      i_result_full  = 1'b0;
    end
`ifdef CE_RESULT_STALL_CNT_EN
    if (stall_mode) chk("stall_cycles", 64'(o_stall_cycles), 64'(exp_stall));
`else
    chk("stall_cycles_off", 64'(o_stall_cycles), 64'(0));
`endif
  endtask

  initial begin
    int fc;
    int cd;
    int acc;
    int g;
    i_reset_n       = 1'b0;
    i_tile_en       = 1'b0;
    i_tile_expected = '0;
    i_res_valid     = 1'b0;
    i_res_data      = '0;
    i_result_full   = 1'b0;
    i_result_afull  = 1'b0;
    model_clear(0);
    exp_stall = 0;

    do_reset();
    check_reset_outputs();

    // Full words, latency and throughput.
    valid_cycles.delete();
    run_tile(8, 100, 0, 0, 0, 0, fc, cd);
    chk("t8_words", 64'(valid_cycles.size()), 64'(2));
    if (valid_cycles.size() >= 2) begin
      chk("t8_lat_w0", 64'(valid_cycles[0] - fc), 64'(5));
      chk("t8_lat_w1", 64'(valid_cycles[1] - fc), 64'(9));
    end else begin
      chk("t8_lat_missing", 64'(valid_cycles.size()), 64'(2));
    end

    // Partial last word.
    valid_cycles.delete();
    run_tile(6, 100, 0, 0, 0, 0, fc, cd);
    chk("t6_words", 64'(valid_cycles.size()), 64'(2));

    // Empty tile.
    valid_cycles.delete();
    run_tile(0, 100, 0, 0, 0, 0, fc, cd);
    chk("t0_done_latency", 64'(cd), 64'(0));
    chk("t0_words", 64'(valid_cycles.size()), 64'(0));

    // Backpressure: FIFO fills, nothing lost.
    valid_cycles.delete();
    run_tile(40, 100, 0, 0, 1, 0, fc, cd);
    chk("t40_words", 64'(valid_cycles.size()), 64'(10));

    // Randomized tiles with random valid and backpressure.
    for (int t = 0; t < 8; t++) begin
      run_tile(int'($urandom_range(1, 37)), int'($urandom_range(40, 100)), 30, 10, 0, 0, fc, cd);
    end
    chk("err_clean", 64'(o_err), 64'(0));

    // Tile start while busy: flagged, ignored.
    run_tile(8, 100, 0, 0, 0, 1, fc, cd);
    chk("err_tile_en_busy", 64'(o_err), 64'(1));

    // Result while idle: flagged, dropped.
    do_reset();
    @(negedge clk);
    i_res_valid = 1'b1;
    i_res_data  = RES_W'($urandom);
    @(negedge clk);
    i_res_valid = 1'b0;
    @(negedge clk);
    chk("err_valid_idle", 64'(o_err), 64'(1));
    chk("err_idle_state", 64'(o_state), 64'(0));
    chk("err_idle_count", 64'(o_result_count), 64'(0));
    chk("err_idle_words", 64'(valid_cycles.size()), 64'(0));

    // Reset mid-tile with three words buffered.
    do_reset();
    @(negedge clk);
    i_tile_en       = 1'b1;
    i_tile_expected = CNT_W'(20);
    model_clear(20);
    i_result_afull  = 1'b1;
    @(negedge clk);
    i_tile_en = 1'b0;
    acc = 0;
    g   = 0;
    while (acc < 12 && g < 100) begin
      i_res_valid = 1'b1;
      i_res_data  = RES_W'($urandom);
      if (o_res_ready) begin
        model_accept(i_res_data);
        acc++;
      end
      g++;
      @(negedge clk);
    end
    i_res_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_state", 64'(o_state), 64'(1));
    chk("mid_count", 64'(o_result_count), 64'(12));
    chk("mid_no_words", 64'(valid_cycles.size()), 64'(0));
    i_reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    exp_data_q.delete();
    exp_keep_q.delete();
    valid_cycles.delete();
    i_result_afull = 1'b0;
    i_reset_n      = 1'b1;
    run_tile(4, 100, 0, 0, 0, 0, fc, cd);
    chk("post_rst_words", 64'(valid_cycles.size()), 64'(1));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
